// File: rtl/machine_csr_file.sv
// -----------------------------------------------------------------------------
// machine_csr_file
//
// Machine-mode CSR file for the pipeline core. Holds the trap-handling CSRs
// (mstatus, mie, mtvec, mscratch, mepc, mcause), the read-only mip/mhartid
// views, and the 64-bit mcycle/minstret counters with mcountinhibit. It
// arbitrates interrupts with a fixed priority and computes the redirect
// target (direct or vectored) for the fetch stage.
//
// Parameters
//   NUM_LOCAL_IRQ  local interrupt lines (1..16); line i lives at mip/mie[16+i]
//   HART_ID        value read back from mhartid
//   MTVEC_RESET    reset value of mtvec (bits [1:0] cleared)
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   csr_address/op/write_data   CSR access: op 00 none, 01 write, 10 set, 11 clear
//   csr_read_data               pre-update value of the addressed CSR (comb.)
//   illegal_csr_access          unimplemented CSR, or modifying a read-only one
//   exception_*                 synchronous exception request, PC and cause
//   machine_return_enable       MRET executes this cycle
//   instruction_retire          one instruction retires this cycle
//   *_interrupt_request         MSIP, MTIP and local interrupt levels
//   trap_vector_out             redirect PC for a trap taken this cycle
//   mepc_out                    MRET target
//   interrupt_enable            an interrupt is taken this cycle (comb.)
// -----------------------------------------------------------------------------
module machine_csr_file #(
  parameter int unsigned NUM_LOCAL_IRQ = 4,
  parameter int unsigned HART_ID       = 0,
  parameter logic [31:0] MTVEC_RESET   = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [11:0]              csr_address,
  input  logic [1:0]               csr_op,
  input  logic [31:0]              csr_write_data,
  output logic [31:0]              csr_read_data,
  output logic                     illegal_csr_access,
  input  logic                     exception_enable,
  input  logic [31:0]              exception_program_counter,
  input  logic [31:0]              exception_cause,
  input  logic                     machine_return_enable,
  input  logic                     instruction_retire,
  input  logic                     software_interrupt_request,
  input  logic                     timer_interrupt_request,
  input  logic [NUM_LOCAL_IRQ-1:0] local_interrupt_request,
  output logic [31:0]              trap_vector_out,
  output logic [31:0]              mepc_out,
  output logic                     interrupt_enable
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [11:0] ADDR_MSTATUS       = 12'h300;
  localparam logic [11:0] ADDR_MIE           = 12'h304;
  localparam logic [11:0] ADDR_MTVEC         = 12'h305;
  localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] ADDR_MSCRATCH      = 12'h340;
  localparam logic [11:0] ADDR_MEPC          = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE        = 12'h342;
  localparam logic [11:0] ADDR_MIP           = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE        = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET      = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] ADDR_MHARTID       = 12'hF14;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  // mie keeps MSIE (3), MTIE (7) and one enable per local line.
  localparam logic [31:0] CORE_IRQ_MASK  = 32'h0000_0088;
  localparam logic [31:0] LOCAL_IRQ_MASK = ((32'h1 << NUM_LOCAL_IRQ) - 32'h1) << 16;
  localparam logic [31:0] MIE_MASK       = CORE_IRQ_MASK | LOCAL_IRQ_MASK;
  localparam logic [31:0] HART_ID_VALUE  = 32'(HART_ID);

  // ---------------------------------------------------------------------------
  // Architectural state
  // ---------------------------------------------------------------------------
  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic [31:0] mie_reg;
  logic [31:0] mtvec_reg;
  logic [31:0] mscratch_reg;
  logic [31:0] mepc_reg;
  logic [31:0] mcause_reg;
  logic        inhibit_cy;
  logic        inhibit_ir;
  logic [63:0] mcycle_reg;
  logic [63:0] minstret_reg;

  // ---------------------------------------------------------------------------
  // Derived views
  // ---------------------------------------------------------------------------
  logic [31:0] mstatus_value;
  logic [31:0] mcountinhibit_value;
  logic [31:0] mip_value;
  logic [31:0] pend;
  logic [4:0]  irq_cause;
  logic [31:0] trap_base;
  logic        trap_taken;

  assign mstatus_value       = {24'd0, mstatus_mpie, 3'd0, mstatus_mie, 3'd0};
  assign mcountinhibit_value = {29'd0, inhibit_ir, 1'b0, inhibit_cy};

  // NOTE: every signal assigned in an always_comb gets a default before any
  // branch so that no path leaves it unassigned and a latch is never inferred.
  always_comb begin
    mip_value    = '0;
    mip_value[3] = software_interrupt_request;
    mip_value[7] = timer_interrupt_request;
    for (int i = 0; i < NUM_LOCAL_IRQ; i++) begin
      mip_value[16+i] = local_interrupt_request[i];
    end
  end

  assign pend             = mip_value & mie_reg;
  assign interrupt_enable = mstatus_mie && (pend != 32'd0);
  assign trap_taken       = interrupt_enable || exception_enable;

  // Fixed priority, lowest first so later assignments override: MTIP, MSIP,
  // then local lines in ascending order, leaving the highest local line on top.
  always_comb begin
    irq_cause = 5'd0;
    if (pend[7]) irq_cause = 5'd7;
    if (pend[3]) irq_cause = 5'd3;
    for (int i = 0; i < NUM_LOCAL_IRQ; i++) begin
      if (pend[16+i]) irq_cause = 5'(16 + i);
    end
  end

  // Vectored mode offsets only interrupts; exceptions always go to the base.
  assign trap_base = {mtvec_reg[31:2], 2'b00};
  always_comb begin
    trap_vector_out = trap_base;
    if (mtvec_reg[0] && interrupt_enable) begin
      trap_vector_out = trap_base + {25'd0, irq_cause, 2'b00};
    end
  end

  assign mepc_out = mepc_reg;

  // ---------------------------------------------------------------------------
  // CSR read / decode
  // ---------------------------------------------------------------------------
  logic [31:0] read_value;
  logic        csr_implemented;
  logic        csr_read_only;

  always_comb begin
    read_value      = '0;
    csr_implemented = 1'b1;
    csr_read_only   = 1'b0;
    case (csr_address)
      ADDR_MSTATUS:       read_value = mstatus_value;
      ADDR_MIE:           read_value = mie_reg;
      ADDR_MTVEC:         read_value = mtvec_reg;
      ADDR_MCOUNTINHIBIT: read_value = mcountinhibit_value;
      ADDR_MSCRATCH:      read_value = mscratch_reg;
      ADDR_MEPC:          read_value = mepc_reg;
      ADDR_MCAUSE:        read_value = mcause_reg;
      ADDR_MCYCLE:        read_value = mcycle_reg[31:0];
      ADDR_MCYCLEH:       read_value = mcycle_reg[63:32];
      ADDR_MINSTRET:      read_value = minstret_reg[31:0];
      ADDR_MINSTRETH:     read_value = minstret_reg[63:32];
      ADDR_MIP: begin
        read_value    = mip_value;
        csr_read_only = 1'b1;
      end
      ADDR_MHARTID: begin
        read_value    = HART_ID_VALUE;
        csr_read_only = 1'b1;
      end
      default:            csr_implemented = 1'b0;
    endcase
  end

  assign csr_read_data      = read_value;
  assign illegal_csr_access = !csr_implemented || (csr_read_only && csr_op != OP_NONE);

  // ---------------------------------------------------------------------------
  // CSR write value and per-register strobes
  // ---------------------------------------------------------------------------
  logic [31:0] write_value;
  logic        csr_write;

  always_comb begin
    write_value = read_value;
    case (csr_op)
      OP_WRITE: write_value = csr_write_data;
      OP_SET:   write_value = read_value | csr_write_data;
      OP_CLEAR: write_value = read_value & ~csr_write_data;
      default:  write_value = read_value;
    endcase
  end

  assign csr_write = (csr_op != OP_NONE) && csr_implemented && !csr_read_only;

  logic wr_mstatus, wr_mie, wr_mtvec, wr_mcountinhibit, wr_mscratch;
  logic wr_mepc, wr_mcause, wr_mcycle, wr_mcycleh, wr_minstret, wr_minstreth;

  assign wr_mstatus       = csr_write && (csr_address == ADDR_MSTATUS);
  assign wr_mie           = csr_write && (csr_address == ADDR_MIE);
  assign wr_mtvec         = csr_write && (csr_address == ADDR_MTVEC);
  assign wr_mcountinhibit = csr_write && (csr_address == ADDR_MCOUNTINHIBIT);
  assign wr_mscratch      = csr_write && (csr_address == ADDR_MSCRATCH);
  assign wr_mepc          = csr_write && (csr_address == ADDR_MEPC);
  assign wr_mcause        = csr_write && (csr_address == ADDR_MCAUSE);
  assign wr_mcycle        = csr_write && (csr_address == ADDR_MCYCLE);
  assign wr_mcycleh       = csr_write && (csr_address == ADDR_MCYCLEH);
  assign wr_minstret      = csr_write && (csr_address == ADDR_MINSTRET);
  assign wr_minstreth     = csr_write && (csr_address == ADDR_MINSTRETH);

  // ---------------------------------------------------------------------------
  // Trap state: mstatus, mepc, mcause
  // A trap (interrupt before exception) beats MRET, which beats a CSR op;
  // the losers are dropped for these three registers only.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mepc_reg     <= '0;
      mcause_reg   <= '0;
    end else if (trap_taken) begin
      mepc_reg     <= exception_program_counter & ~32'h3;
      mcause_reg   <= interrupt_enable ? {1'b1, 26'd0, irq_cause} : exception_cause;
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (machine_return_enable) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else begin
      if (wr_mstatus) begin
        mstatus_mie  <= write_value[3];
        mstatus_mpie <= write_value[7];
      end
      if (wr_mepc)   mepc_reg   <= write_value & ~32'h3;
      if (wr_mcause) mcause_reg <= write_value;
    end
  end

  // ---------------------------------------------------------------------------
  // Configuration registers: always writable, regardless of traps
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mie_reg      <= '0;
      mtvec_reg    <= MTVEC_RESET & ~32'h3;
      mscratch_reg <= '0;
      inhibit_cy   <= 1'b0;
      inhibit_ir   <= 1'b0;
    end else begin
      if (wr_mie)      mie_reg      <= write_value & MIE_MASK;
      if (wr_mtvec)    mtvec_reg    <= write_value & ~32'h2;
      if (wr_mscratch) mscratch_reg <= write_value;
      if (wr_mcountinhibit) begin
        inhibit_cy <= write_value[0];
        inhibit_ir <= write_value[2];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // 64-bit counters. A write to one half replaces only that half and
  // suppresses the increment for that cycle; no carry crosses into the
  // other half from a write.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcycle_reg <= '0;
    end else if (wr_mcycle) begin
      mcycle_reg[31:0] <= write_value;
    end else if (wr_mcycleh) begin
      mcycle_reg[63:32] <= write_value;
    end else if (!inhibit_cy) begin
      mcycle_reg <= mcycle_reg + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      minstret_reg <= '0;
    end else if (wr_minstret) begin
      minstret_reg[31:0] <= write_value;
    end else if (wr_minstreth) begin
      minstret_reg[63:32] <= write_value;
    end else if (instruction_retire && !inhibit_ir) begin
      minstret_reg <= minstret_reg + 64'd1;
    end
  end

endmodule

// File: tb/tb_machine_csr_file.sv
// -----------------------------------------------------------------------------
// tb_machine_csr_file
//
// Directed bench for machine_csr_file (NUM_LOCAL_IRQ=4, HART_ID=5,
// MTVEC_RESET=32'h103). A CSR-level model tracks each register as a plain
// word and is checked against the DUT on every negative edge; hand-computed
// literal expectations along the directed sequence pin the model itself.
// -----------------------------------------------------------------------------
module tb_machine_csr_file;

  logic        clk;
  logic        rst_n;
  logic [11:0] csr_address;
  logic [1:0]  csr_op;
  logic [31:0] csr_write_data;
  logic [31:0] csr_read_data;
  logic        illegal_csr_access;
  logic        exception_enable;
  logic [31:0] exception_program_counter;
  logic [31:0] exception_cause;
  logic        machine_return_enable;
  logic        instruction_retire;
  logic        software_interrupt_request;
  logic        timer_interrupt_request;
  logic [3:0]  local_interrupt_request;
  logic [31:0] trap_vector_out;
  logic [31:0] mepc_out;
  logic        interrupt_enable;

  machine_csr_file #(
    .NUM_LOCAL_IRQ(4),
    .HART_ID      (5),
    .MTVEC_RESET  (32'h103)
  ) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .csr_address               (csr_address),
    .csr_op                    (csr_op),
    .csr_write_data            (csr_write_data),
    .csr_read_data             (csr_read_data),
    .illegal_csr_access        (illegal_csr_access),
    .exception_enable          (exception_enable),
    .exception_program_counter (exception_program_counter),
    .exception_cause           (exception_cause),
    .machine_return_enable     (machine_return_enable),
    .instruction_retire        (instruction_retire),
    .software_interrupt_request(software_interrupt_request),
    .timer_interrupt_request   (timer_interrupt_request),
    .local_interrupt_request   (local_interrupt_request),
    .trap_vector_out           (trap_vector_out),
    .mepc_out                  (mepc_out),
    .interrupt_enable          (interrupt_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: each CSR is a plain 32/64-bit word updated by the architectural
  // rules (trap, MRET, CSR op, counters).
  // ---------------------------------------------------------------------------
  localparam logic [31:0] M_MIE_MASK = 32'h000F_0088;

  bit          model_live = 0;
  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_minh;
  logic [63:0] m_cycle, m_instret;

  function automatic logic [31:0] m_mip();
    logic [31:0] v;
    v        = 32'h0;
    v[3]     = software_interrupt_request;
    v[7]     = timer_interrupt_request;
    v[19:16] = local_interrupt_request;
    return v;
  endfunction

  // Cause number of the interrupt taken now, or -1 when none.
  function automatic int m_irq_cause();
    logic [31:0] p;
    int          prio [6];
    prio = '{19, 18, 17, 16, 3, 7};
    p    = m_mip() & m_mie;
    if (!m_mstatus[3]) return -1;
    foreach (prio[k]) if (p[prio[k]]) return prio[k];
    return -1;
  endfunction

  function automatic logic [31:0] m_vector();
    int          c;
    logic [31:0] base;
    c    = m_irq_cause();
    base = m_mtvec & ~32'h3;
    if (m_mtvec[0] && c >= 0) return base + 32'(4 * c);
    return base;
  endfunction

  task automatic m_lookup(input logic [11:0] a, output logic [31:0] v,
                          output bit impl, output bit ro);
    impl = 1; ro = 0; v = 32'h0;
    case (a)
      12'h300: v = m_mstatus;
      12'h304: v = m_mie;
      12'h305: v = m_mtvec;
      12'h320: v = m_minh;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h344: begin v = m_mip(); ro = 1; end
      12'hB00: v = m_cycle[31:0];
      12'hB80: v = m_cycle[63:32];
      12'hB02: v = m_instret[31:0];
      12'hB82: v = m_instret[63:32];
      12'hF14: begin v = 32'd5; ro = 1; end
      default: impl = 0;
    endcase
  endtask

  int          u_c;
  logic [31:0] u_old, u_wv;
  bit          u_impl, u_ro, u_do;
  logic [31:0] u_inh;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mstatus = 0; m_mie = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
      m_minh = 0; m_cycle = 0; m_instret = 0;
      m_mtvec = 32'h100;
      model_live = 1;
    end else if (model_live) begin
      u_c = m_irq_cause();
      m_lookup(csr_address, u_old, u_impl, u_ro);
      case (csr_op)
        2'b01:   u_wv = csr_write_data;
        2'b10:   u_wv = u_old | csr_write_data;
        2'b11:   u_wv = u_old & ~csr_write_data;
        default: u_wv = u_old;
      endcase
      u_do  = (csr_op != 2'b00) && u_impl && !u_ro;
      u_inh = m_minh;

      if (u_c >= 0 || exception_enable) begin
        m_mepc    = exception_program_counter & ~32'h3;
        m_mcause  = (u_c >= 0) ? (32'h8000_0000 | 32'(u_c)) : exception_cause;
        m_mstatus = m_mstatus[3] ? 32'h80 : 32'h00;
      end else if (machine_return_enable) begin
        m_mstatus = (m_mstatus[7] ? 32'h08 : 32'h00) | 32'h80;
      end else if (u_do) begin
        if (csr_address == 12'h300) m_mstatus = u_wv & 32'h88;
        if (csr_address == 12'h341) m_mepc    = u_wv & ~32'h3;
        if (csr_address == 12'h342) m_mcause  = u_wv;
      end

      if (u_do && csr_address == 12'h304) m_mie      = u_wv & M_MIE_MASK;
      if (u_do && csr_address == 12'h305) m_mtvec    = u_wv & ~32'h2;
      if (u_do && csr_address == 12'h340) m_mscratch = u_wv;
      if (u_do && csr_address == 12'h320) m_minh     = u_wv & 32'h5;

      if (u_do && csr_address == 12'hB00)      m_cycle[31:0]  = u_wv;
      else if (u_do && csr_address == 12'hB80) m_cycle[63:32] = u_wv;
      else if (!u_inh[0])                      m_cycle        = m_cycle + 64'd1;

      if (u_do && csr_address == 12'hB02)      m_instret[31:0]  = u_wv;
      else if (u_do && csr_address == 12'hB82) m_instret[63:32] = u_wv;
      else if (instruction_retire && !u_inh[2]) m_instret       = m_instret + 64'd1;
    end
  end

  // Compare process: every cycle the DUT is out of reset.
  logic [31:0] c_val;
  bit          c_impl, c_ro;

  always @(negedge clk) begin
    if (model_live && rst_n) begin
      m_lookup(csr_address, c_val, c_impl, c_ro);
      check("model csr_read_data", csr_read_data, c_val);
      check("model illegal_csr_access", 32'(illegal_csr_access),
            32'(!c_impl || (c_ro && csr_op != 2'b00)));
      check("model interrupt_enable", 32'(interrupt_enable), 32'(m_irq_cause() >= 0));
      check("model trap_vector_out", trap_vector_out, m_vector());
      check("model mepc_out", mepc_out, m_mepc);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic idle();
    csr_address                = 12'h340;
    csr_op                     = 2'b00;
    csr_write_data             = 32'h0;
    exception_enable           = 1'b0;
    exception_program_counter  = 32'h0;
    exception_cause            = 32'h0;
    machine_return_enable      = 1'b0;
    instruction_retire         = 1'b0;
    software_interrupt_request = 1'b0;
    timer_interrupt_request    = 1'b0;
    local_interrupt_request    = 4'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
    idle();
    csr_address    = a;
    csr_op         = op;
    csr_write_data = d;
  endtask

  task automatic csr_cycle(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
    drive(a, op, d);
    tick();
  endtask

  task automatic read_expect(input string name, input logic [11:0] a, input logic [31:0] exp);
    drive(a, 2'b00, 32'h0);
    @(negedge clk);
    check(name, csr_read_data, exp);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    drive(12'hB00, 2'b00, 32'h0);
    @(negedge clk);
    check("reset mcycle", csr_read_data, 32'h0);
    check("reset illegal", 32'(illegal_csr_access), 32'h0);
    check("reset trap_vector", trap_vector_out, 32'h100);
    check("reset mepc_out", mepc_out, 32'h0);
    check("reset interrupt_enable", 32'(interrupt_enable), 32'h0);
    tick();
    read_expect("reset mtvec", 12'h305, 32'h100);

    // Vectored interrupt on local line 1
    csr_cycle(12'h305, 2'b01, 32'h201);
    csr_cycle(12'h304, 2'b01, 32'h0002_0000);
    csr_cycle(12'h300, 2'b01, 32'h8);
    idle();
    local_interrupt_request   = 4'b0010;
    exception_program_counter = 32'h400;
    @(negedge clk);
    check("local1 interrupt_enable", 32'(interrupt_enable), 32'h1);
    check("local1 trap_vector", trap_vector_out, 32'h244);
    tick();
    drive(12'h341, 2'b00, 32'h0);
    @(negedge clk);
    check("local1 mepc_out", mepc_out, 32'h400);
    tick();
    read_expect("local1 mcause", 12'h342, 32'h8000_0011);
    read_expect("local1 mstatus", 12'h300, 32'h80);

    // mie WARL mask, then priority among local 0, MSIP and MTIP
    csr_cycle(12'h304, 2'b01, 32'hFFFF_FFFF);
    read_expect("mie mask", 12'h304, 32'h000F_0088);
    csr_cycle(12'h300, 2'b01, 32'h8);
    idle();
    local_interrupt_request    = 4'b0001;
    software_interrupt_request = 1'b1;
    timer_interrupt_request    = 1'b1;
    exception_program_counter  = 32'h404;
    @(negedge clk);
    check("prio trap_vector", trap_vector_out, 32'h240);
    tick();
    read_expect("prio mcause", 12'h342, 32'h8000_0010);
    read_expect("prio mstatus", 12'h300, 32'h80);

    // MRET beats a same-cycle write to mstatus
    drive(12'h300, 2'b01, 32'h0);
    machine_return_enable = 1'b1;
    tick();
    read_expect("mret mstatus", 12'h300, 32'h88);

    // Exception with a pending MTIP: interrupt wins; mscratch write still lands
    drive(12'h340, 2'b01, 32'hAB);
    timer_interrupt_request   = 1'b1;
    exception_enable          = 1'b1;
    exception_cause           = 32'd11;
    exception_program_counter = 32'h503;
    @(negedge clk);
    check("exc+mtip interrupt_enable", 32'(interrupt_enable), 32'h1);
    check("exc+mtip trap_vector", trap_vector_out, 32'h21C);
    tick();
    read_expect("exc+mtip mcause", 12'h342, 32'h8000_0007);
    read_expect("exc+mtip mepc", 12'h341, 32'h500);
    read_expect("exc+mtip mscratch", 12'h340, 32'hAB);

    // Plain exception in vectored mode goes to the base
    idle();
    exception_enable          = 1'b1;
    exception_cause           = 32'd11;
    exception_program_counter = 32'h600;
    @(negedge clk);
    check("exc trap_vector", trap_vector_out, 32'h200);
    tick();
    read_expect("exc mcause", 12'h342, 32'h0000_000B);
    read_expect("exc mstatus", 12'h300, 32'h0);

    // WARL on mstatus and mtvec, set/clear on mstatus
    csr_cycle(12'h300, 2'b01, 32'hFFFF_FFFF);
    read_expect("mstatus mask", 12'h300, 32'h88);
    csr_cycle(12'h300, 2'b11, 32'h8);
    read_expect("mstatus clear", 12'h300, 32'h80);
    csr_cycle(12'h305, 2'b01, 32'h303);
    read_expect("mtvec bit1", 12'h305, 32'h301);

    // Set / clear on mscratch
    csr_cycle(12'h340, 2'b01, 32'hF0);
    csr_cycle(12'h340, 2'b10, 32'h0F);
    read_expect("mscratch set", 12'h340, 32'hFF);
    csr_cycle(12'h340, 2'b11, 32'h3C);
    read_expect("mscratch clear", 12'h340, 32'hC3);

    // Read-only and unimplemented CSRs
    drive(12'hF14, 2'b01, 32'h99);
    @(negedge clk);
    check("mhartid write illegal", 32'(illegal_csr_access), 32'h1);
    tick();
    drive(12'hF14, 2'b00, 32'h0);
    @(negedge clk);
    check("mhartid value", csr_read_data, 32'h5);
    check("mhartid read legal", 32'(illegal_csr_access), 32'h0);
    tick();
    drive(12'h344, 2'b10, 32'h1);
    software_interrupt_request = 1'b1;
    @(negedge clk);
    check("mip set illegal", 32'(illegal_csr_access), 32'h1);
    check("mip value", csr_read_data, 32'h8);
    tick();
    drive(12'h7C0, 2'b00, 32'h0);
    @(negedge clk);
    check("unimpl illegal", 32'(illegal_csr_access), 32'h1);
    check("unimpl read", csr_read_data, 32'h0);
    tick();

    // 64-bit mcycle wrap
    csr_cycle(12'hB00, 2'b01, 32'hFFFF_FFFF);
    csr_cycle(12'hB80, 2'b01, 32'hFFFF_FFFF);
    read_expect("mcycle all ones", 12'hB00, 32'hFFFF_FFFF);
    read_expect("mcycle wrapped", 12'hB00, 32'h0);
    read_expect("mcycleh wrapped", 12'hB80, 32'h0);

    // minstret: write suppresses the increment, then counts retires
    drive(12'hB02, 2'b01, 32'h10);
    instruction_retire = 1'b1;
    tick();
    drive(12'hB02, 2'b00, 32'h0);
    instruction_retire = 1'b1;
    @(negedge clk);
    check("minstret after write", csr_read_data, 32'h10);
    tick();
    read_expect("minstret counted", 12'hB02, 32'h11);

    // mcountinhibit stops both counters
    csr_cycle(12'h320, 2'b01, 32'hFFFF_FFFF);
    read_expect("mcountinhibit mask", 12'h320, 32'h5);
    csr_cycle(12'hB00, 2'b01, 32'h1234);
    csr_cycle(12'hB02, 2'b01, 32'h55);
    for (int i = 0; i < 3; i++) begin
      drive(12'hB00, 2'b00, 32'h0);
      instruction_retire = 1'b1;
      tick();
    end
    read_expect("mcycle inhibited", 12'hB00, 32'h1234);
    drive(12'hB02, 2'b00, 32'h0);
    instruction_retire = 1'b1;
    @(negedge clk);
    check("minstret inhibited", csr_read_data, 32'h55);
    tick();

    // Reset asserted together with a trap: reset wins
    idle();
    exception_enable          = 1'b1;
    exception_cause           = 32'd2;
    exception_program_counter = 32'h700;
    rst_n                     = 1'b0;
    tick();
    rst_n = 1'b1;
    read_expect("reset-trap mepc", 12'h341, 32'h0);
    read_expect("reset-trap mcause", 12'h342, 32'h0);
    read_expect("reset-trap mtvec", 12'h305, 32'h100);
    read_expect("reset-trap mscratch", 12'h340, 32'h0);
    read_expect("reset-trap mstatus", 12'h300, 32'h0);

    idle();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
